// File: rtl/clock_reset_manager_if.sv
// Control/status bundle for clock_reset_manager: lock and soft-reset inputs,
// system reset, clock enables and debug status outputs.
interface clock_reset_manager_if #(
    parameter int NUM_CH = 3
);
    logic              pll_locked;
    logic              soft_reset;
    logic              sys_resetb;
    logic [NUM_CH-1:0] ce;
    logic [1:0]        state;
    logic [7:0]        lock_loss_cnt;

    modport master (
        output pll_locked,
        output soft_reset,
        input  sys_resetb,
        input  ce,
        input  state,
        input  lock_loss_cnt
    );

    modport slave (
        input  pll_locked,
        input  soft_reset,
        output sys_resetb,
        output ce,
        output state,
        output lock_loss_cnt
    );
endinterface

// File: rtl/clock_reset_manager.sv
// Lock-qualified system reset plus phase-aligned clock-enable dividers.
// `define SIM_FAST_LOCK_EN shortens lock qualification to 16 cycles for simulation.
module clock_reset_manager #(
    parameter int                        NUM_CH      = 3,
    parameter int                        DIV_W       = 8,
    parameter logic [NUM_CH*DIV_W-1:0]   DIVS        = {8'd9, 8'd3, 8'd0},
    parameter int unsigned               LOCK_CYCLES = 1024
) (
    input  logic                   clock_in,
    input  logic                   resetb,
    clock_reset_manager_if.slave   bus
);

`ifdef SIM_FAST_LOCK_EN
    localparam int unsigned EFF_LOCK = 16;
`else
    localparam int unsigned EFF_LOCK = LOCK_CYCLES;
`endif
    localparam int unsigned CNT_W = $clog2(EFF_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(EFF_LOCK - 1);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             sync1_q, locked_s_q;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [7:0]       loss_cnt_q, loss_cnt_d;
    logic             sys_resetb_q, sys_resetb_d;
    logic [NUM_CH-1:0] ce;

    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= bus.pll_locked;
            locked_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_WAIT;
            lock_cnt_q   <= '0;
            loss_cnt_q   <= '0;
            sys_resetb_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            sys_resetb_q <= sys_resetb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        loss_cnt_d = loss_cnt_q;
        lock_cnt_d = '0;
        if (state_q == ST_WAIT && locked_s_q && !bus.soft_reset)
            lock_cnt_d = lock_cnt_q + 1'b1;

        case (state_q)
            ST_WAIT: begin
                if (locked_s_q && lock_cnt_q == LOCK_LAST)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                // Lock loss outranks soft_reset so every loss is counted.
                if (!locked_s_q) begin
                    state_d = ST_FAULT;
                    if (loss_cnt_q != 8'hFF)
                        loss_cnt_d = loss_cnt_q + 8'd1;
                end else if (bus.soft_reset) begin
                    state_d = ST_WAIT;
                end
            end
            ST_FAULT: state_d = ST_WAIT;
            default:  state_d = ST_WAIT;
        endcase

        sys_resetb_d = (state_d == ST_RUN);
    end

    // Dividers sit at zero while in reset so every release restarts them in phase.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_div
        localparam logic [DIV_W-1:0] DIV_VAL = DIVS[g*DIV_W +: DIV_W];
        logic [DIV_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q + 1'b1;
            if (!sys_resetb_q || cnt_q == DIV_VAL)
                cnt_d = '0;
        end

        always_ff @(posedge clock_in or negedge resetb) begin
            if (!resetb)
                cnt_q <= '0;
            else
                cnt_q <= cnt_d;
        end

        assign ce[g] = sys_resetb_q & (cnt_q == DIV_VAL);
    end

    assign bus.sys_resetb    = sys_resetb_q;
    assign bus.ce            = ce;
    assign bus.state         = state_q;
    assign bus.lock_loss_cnt = loss_cnt_q;

endmodule
